// File: rtl/cmac_array_pkg.sv
// Shared types and helpers for the convolution MAC array and its downstream
// pooling/bias blocks.
package cmac_array_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Accumulator must hold kernel_len full-width products without wrapping.
  function automatic bit acc_w_ok(input int unsigned acc_w,
                                  input int unsigned data_w,
                                  input int unsigned len_w);
    return acc_w >= 2 * data_w + len_w;
  endfunction

  // Floor-shift then clamp to a signed out_w range; caller casts to out_w bits.
  function automatic logic signed [127:0] sat_shift(input logic signed [127:0] acc,
                                                    input int unsigned         shift,
                                                    input int unsigned         out_w);
    logic signed [127:0] sh;
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    sh = acc >>> shift;
    hi = (128'sd1 <<< (out_w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (out_w - 1));
    if (sh > hi) begin
      return hi;
    end
    if (sh < lo) begin
      return lo;
    end
    return sh;
  endfunction

endpackage

// File: rtl/cmac_array_lane.sv
// One MAC lane: MUL_LAT-stage registered signed multiplier feeding a
// wrap-around accumulator with synchronous clear.
module cmac_lane
  import cmac_array_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     acc_en_i,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic signed [DATA_W-1:0] weight_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic signed [PROD_W-1:0] prod_d;
  logic signed [PROD_W-1:0] prod_q [MUL_LAT];
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  acc_q;

  always_comb begin
    prod_d = PROD_W'(data_i) * PROD_W'(weight_i);
  end

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (acc_en_i) begin
      acc_d = acc_q + ACC_W'(prod_q[MUL_LAT-1]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < MUL_LAT; i++) begin
        prod_q[i] <= '0;
      end
      acc_q <= '0;
    end else begin
      prod_q[0] <= prod_d;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        prod_q[i] <= prod_q[i-1];
      end
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cmac_array.sv
// LANES-wide convolution MAC array: shared data stream, per-lane weights,
// programmable kernel length, shifted/saturated results behind valid/ready.
module cmac_array
  import cmac_array_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ACC_W      = 40,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned FRAC_SHIFT = 8,
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned MUL_LAT    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        kernel_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       data,
  input  logic [LANES*DATA_W-1:0] weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*OUT_W-1:0]  result,
  output logic                    busy,
  output logic                    done
);

  localparam bit AccWOk = acc_w_ok(ACC_W, DATA_W, LEN_W);

  if (!AccWOk) begin : g_acc_w_check
    $error("cmac_array: ACC_W must be at least 2*DATA_W + LEN_W");
  end

  state_e                 state_q, state_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       cnt_q, cnt_d;
  logic [LANES*OUT_W-1:0] result_q, result_d;
  logic [MUL_LAT-1:0]     vld_q;
  logic                   accept;
  logic                   clr;
  logic signed [ACC_W-1:0] lane_acc [LANES];
  logic [LANES*OUT_W-1:0] lane_sat;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cmac_lane #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .MUL_LAT (MUL_LAT)
    ) u_lane (
      .clk_i    (clk),
      .rst_ni   (rst),
      .clr_i    (clr),
      .acc_en_i (vld_q[MUL_LAT-1]),
      .data_i   (data),
      .weight_i (weight[g*DATA_W +: DATA_W]),
      .acc_o    (lane_acc[g])
    );

    assign lane_sat[g*OUT_W +: OUT_W] = OUT_W'(sat_shift(128'(lane_acc[g]), FRAC_SHIFT, OUT_W));
  end

  assign in_ready  = (state_q == ST_ACCUM) && (cnt_q < len_q);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_OUT);
  assign done      = out_valid && out_ready;
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    clr      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d    = kernel_len;
          cnt_d    = '0;
          clr      = 1'b1;
          result_d = '0;
          state_d  = (kernel_len == '0) ? ST_OUT : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Empty tags mean the last product was folded in on the previous edge.
        if (vld_q == '0) begin
          result_d = lane_sat;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= accept;
      for (int unsigned i = 1; i < MUL_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_cmac_array.sv
// Directed-vector bench for cmac_array with hand-computed lane results,
// plus reset-abort and handshake corner sequences.
module tb_cmac_array;

  localparam int LANES   = 4;
  localparam int DW      = 16;
  localparam int OW      = 16;
  localparam int MUL_LAT = 2;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        start      = 1'b0;
  logic [7:0]  kernel_len = '0;
  logic        in_valid   = 1'b0;
  logic        in_ready;
  logic [15:0] data       = '0;
  logic [63:0] weight     = '0;
  logic        out_valid;
  logic        out_ready  = 1'b0;
  logic [63:0] result;
  logic        busy;
  logic        done;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cmac_array #(
    .LANES      (LANES),
    .DATA_W     (DW),
    .ACC_W      (40),
    .OUT_W      (OW),
    .FRAC_SHIFT (8),
    .LEN_W      (8),
    .MUL_LAT    (MUL_LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kernel_len (kernel_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .weight     (weight),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    string       name;
    int          len;
    int          d0;
    int          dstep;
    logic [63:0] w;
    logic [63:0] ex;
    bit          gaps;
    bit          stall;
    bit          mid_start;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic run(input vec_t v);
    int          k;
    int          cyc;
    int          lat;
    bit          bad;
    logic [63:0] held;
    bad = 1'b0;
    @(negedge clk);
    start      = 1'b1;
    kernel_len = 8'(v.len);
    weight     = v.w;
    @(negedge clk);
    start      = 1'b0;
    kernel_len = 8'hAA;
    k   = 0;
    cyc = 0;
    while (k < v.len && cyc < 2000) begin
      in_valid = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      data     = 16'(v.d0 + k * v.dstep);
      if (v.mid_start && k == 1) begin
        start      = 1'b1;
        kernel_len = 8'd7;
      end else begin
        start = 1'b0;
      end
      if (in_valid && in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({v.name, "_beats"}, 64'(k), 64'(v.len));
    in_valid = 1'b1;
    data     = 16'h7FFF;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (in_ready) bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk({v.name, "_latency"}, 64'(lat), (v.len == 0) ? 64'd0 : 64'(MUL_LAT + 1));
    chk({v.name, "_result"}, result, v.ex);
    if (in_ready) bad = 1'b1;
    if (v.stall) begin
      out_ready = 1'b0;
      held      = result;
      repeat (10) begin
        @(negedge clk);
        if (result !== held || !out_valid || done || in_ready) bad = 1'b1;
      end
    end
    out_ready = 1'b1;
    #1;
    chk({v.name, "_done_on_accept"}, 64'(done), 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk({v.name, "_after_handshake"}, 64'({out_valid, busy, done}), 64'd0);
    chk({v.name, "_quiet_outside_accum"}, 64'(bad), 64'd0);
  endtask

  initial begin
    vec_t rv;
    int   k;
    int   cyc;
    bit   seen;

    vecs[0] = '{"basic",     3,    256, 256, p4(256, 0, 0, 0),              p4(1536, 0, 0, 0),          0, 0, 0};
    vecs[1] = '{"pos_sat",   2,  32767,   0, p4(32767, 32767, 32767, 32767), p4(32767, 32767, 32767, 32767), 0, 0, 0};
    vecs[2] = '{"neg_floor", 1,     -1,   0, p4(1, 1, 1, 1),                p4(-1, -1, -1, -1),         0, 0, 0};
    vecs[3] = '{"neg_sat",   4, -32768,   0, p4(32767, 32767, 32767, 32767), p4(-32768, -32768, -32768, -32768), 0, 0, 0};
    vecs[4] = '{"len0",      0,      5,   0, p4(9, 9, 9, 9),                p4(0, 0, 0, 0),             0, 0, 0};
    vecs[5] = '{"mixed_mid_start", 3, 100, 100, p4(3, -5, 1000, -1),        p4(7, -12, 2343, -3),       0, 0, 1};
    vecs[6] = '{"stress",    5,     10,  10, p4(256, -256, 512, 7),         p4(150, -150, 300, 4),      1, 1, 0};
    vecs[7] = '{"len255",  255,      1,   0, p4(256, 256, 256, 256),        p4(255, 255, 255, 255),     0, 0, 0};

    #1 rst = 1'b0;
    #3;
    chk("reset_outputs", {59'd0, in_ready, out_valid, busy, done, |result}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run(vecs[i]);
    end

    // Abort a len=4 kernel after two accepted beats.
    @(negedge clk);
    start      = 1'b1;
    kernel_len = 8'd4;
    weight     = p4(256, 256, 256, 256);
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    data     = 16'd256;
    k   = 0;
    cyc = 0;
    while (k < 2 && cyc < 20) begin
      if (in_ready) k++;
      @(negedge clk);
      cyc++;
    end
    chk("abort_beats", 64'(k), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("abort_result", result, 64'd0);
    chk("abort_flags", 64'({in_ready, out_valid, busy, done}), 64'd0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid || busy) seen = 1'b1;
    end
    chk("abort_no_output", 64'(seen), 64'd0);

    rv = '{"reset_recover", 1, 256, 0, p4(256, 256, 256, 256), p4(256, 256, 256, 256), 0, 0, 0};
    run(rv);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cmac_array.md
Name: cmac_array

Overview:
- Parametrised successor to the single-lane convolution multiply unit.
- LANES parallel signed fixed-point multiply-accumulate lanes share one data stream. Each lane has its own weight.
- Each lane accumulates over a programmable kernel length, then rescales and saturates its result. All lane results are presented together behind a valid/ready handshake.
- Sits between the convolution data/weight fetch logic and the output write-back buffer.

Parameters:
- LANES, 4, number of parallel MAC lanes (output channels).
- DATA_W, 16, signed width of data and weight operands.
- ACC_W, 40, signed accumulator width. Must be ≥ 2*DATA_W + LEN_W; checked at elaboration.
- OUT_W, 16, signed width of each lane result.
- FRAC_SHIFT, 8, arithmetic right shift applied to the accumulator before saturation.
- LEN_W, 8, width of kernel_len.
- MUL_LAT, 2, multiplier pipeline depth in cycles (≥1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a kernel. Sampled only in IDLE.
- kernel_len  in  LEN_W  number of data/weight beats to accumulate. Latched on start.
- in_valid  in  1  data/weight beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- data  in  DATA_W  shared signed data operand.
- weight  in  LANES*DATA_W  per-lane signed weights; lane i occupies bits [i*DATA_W +: DATA_W].
- out_valid  out  1  result bus valid.
- out_ready  in  1  downstream accepts the result.
- result  out  LANES*OUT_W  per-lane saturated results, packed the same way as weight.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the result handshake.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; accumulators, counters and the multiplier pipeline cleared; in_ready=0, out_valid=0, result=0, busy=0, done=0.
- States: IDLE, ACCUM, DRAIN, OUT.
- IDLE:
  - On start, latch kernel_len, clear accumulators and the beat counter.
  - If kernel_len≠0, go to ACCUM. If kernel_len=0, go directly to OUT with all results 0.
- ACCUM:
  - in_ready=1 while beat count < latched length.
  - A beat is accepted when in_valid && in_ready. It enters the multiplier pipeline with a valid tag, and the count increments.
  - The multiply is a full 2*DATA_W signed product per lane.
  - A product leaving the pipeline is sign-extended and added into its ACC_W accumulator in the same cycle.
  - Accumulation wraps modulo 2^ACC_W; no overflow detection.
  - When the final beat is accepted, in_ready drops in the next cycle and the state goes to DRAIN.
- DRAIN:
  - Waits until all in-flight products have been accumulated, i.e. the pipeline valid tags are empty: MUL_LAT cycles after the last acceptance.
  - Then registers the results and goes to OUT.
- Result formatting (per lane):
  - Arithmetic right shift of the accumulator by FRAC_SHIFT (truncation toward −inf).
  - Clamp to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- OUT:
  - out_valid=1; result is held stable until out_ready.
  - On out_valid && out_ready: done pulses for one cycle, out_valid drops next cycle, and the state returns to IDLE.
- Latency: last accepted beat → out_valid rises MUL_LAT+1 cycles later.
- Minimum IDLE→IDLE turnaround is kernel_len+MUL_LAT+3 cycles with continuous in_valid and out_ready.
- start outside IDLE is ignored. in_valid outside ACCUM is ignored and consumes no beat.
- A gap in in_valid stalls the count only. In-flight products still drain and accumulate.
- Reset mid-operation aborts immediately. No partial result is emitted.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/ACCUM/DRAIN/OUT);
  - the saturating-shift function (accumulator → OUT_W), reused by later pooling/bias blocks;
  - the ACC_W sizing check as an elaborated constant.
- One sub-module, cmac_lane: per-lane pipelined signed multiplier (MUL_LAT stages) plus accumulator, with clear and accumulate-enable inputs.
- cmac_array instantiates LANES copies of cmac_lane via generate and owns the FSM, beat counter, valid-tag shift register and output registers.

Test Plan:
- Basic kernel (defaults): kernel_len=3, data=256,512,768; lane0 weights=256 each; lanes1-3=0. Expected: lane0 acc=393216, result = 393216>>8 = 1536; other lanes 0; out_valid 3 cycles after the last beat; done pulses once.
- Positive saturation: kernel_len=2, data=32767, all weights=32767. Expected: acc≈2.147e9, shifted value exceeds range, all lanes output 32767.
- Negative saturation and rounding: kernel_len=1, data=−1, weights=1. Expected result=−1 (floor). Then kernel_len=4, data=−32768, weights=32767. Expected all lanes −32768.
- Handshake stress: random in_valid gaps plus out_ready held low 10 cycles, kernel_len=5 with known values. Expected:
  - result unchanged while stalled;
  - no beats accepted outside ACCUM;
  - done coincident with the accepting out_ready cycle only;
  - result matches the golden model.
- Boundary: kernel_len=0 → out_valid with all zeros 1 cycle after start, in_ready never asserts. kernel_len=255 with data=1, weights=256 → result=255. start pulsed during ACCUM has no effect.
- Reset mid-kernel: drop rst after 2 of 4 beats. Expected: all outputs zero immediately, busy=0, no out_valid. Next kernel (len=1, data=256, weight=256) → result=256, uncorrupted.
